// File: rtl/intctrl_prio.sv
// Prioritised interrupt controller: byte-lane register bus, edge/level sources, registered 68k-style IPL output.
// Define INTCTRL_VECTORED_EN to answer CPU iack cycles with a vector number; otherwise iack is ignored (autovectors).
module intctrl_prio #(
  parameter int         NUM_IRQ     = 8,
  parameter logic [7:0] VECTOR_BASE = 8'h40
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        data_write,
  output logic [15:0]        data_read,
  input  logic [7:0]         addr,
  input  logic               uds,
  input  logic               lds,
  input  logic               rw,
  input  logic               as,
  output logic               ack,
  input  logic               iack,
  input  logic [2:0]         iack_level,
  output logic [2:0]         ipl_n,
  input  logic [NUM_IRQ-1:0] interrupts
);

  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_ACK   = 2'd1;
  localparam logic [1:0]  ST_HOLD  = 2'd2;
  localparam logic [15:0] IRQ_MASK = 16'((32'd1 << NUM_IRQ) - 32'd1);

  logic [1:0]  state;
  logic        ctrl_en;
  logic [15:0] enable_r;
  logic [15:0] pending_r;
  logic [15:0] mode_r;
  logic [15:0] irq_p0;
  logic [2:0]  prio_r [16];

  logic [15:0] irq_in;
  logic [15:0] lane_mask;
  logic [15:0] wr_bits;
  logic [15:0] clr_bits;
  logic [15:0] set_bits;
  logic [15:0] pending_nxt;
  logic [15:0] active;
  logic [15:0] reg_rd;
  logic [15:0] rd_val;
  logic [6:0]  word;
  logic        go;
  logic        do_iack;
  logic        do_wr;
  logic        vec_hit;
  logic [3:0]  vec_idx;
  logic [2:0]  max_lvl;
  logic        unused_addr0;

  function automatic logic [15:0] merge(input logic [15:0] cur, input logic [15:0] wd,
                                        input logic [15:0] lanes);
    return ((cur & ~lanes) | (wd & lanes)) & IRQ_MASK;
  endfunction

  assign irq_in       = 16'(interrupts);
  assign word         = addr[7:1];
  assign unused_addr0 = addr[0];
  assign lane_mask    = {{8{uds}}, {8{lds}}};
  assign wr_bits      = data_write & lane_mask;

`ifdef INTCTRL_VECTORED_EN
  assign go      = (state == ST_IDLE) && as;
  assign do_iack = go && iack;
`else
  assign go      = (state == ST_IDLE) && as && !iack;
  assign do_iack = 1'b0;
`endif
  assign do_wr = go && !do_iack && !rw;

  // Descending scan so the lowest index wins a vector tie.
  always_comb begin
    active  = '0;
    max_lvl = '0;
    vec_hit = 1'b0;
    vec_idx = '0;
    for (int i = 15; i >= 0; i--) begin
      active[i] = ctrl_en && enable_r[i] && pending_r[i] && (prio_r[i] != 3'd0);
      if (active[i] && (prio_r[i] > max_lvl)) max_lvl = prio_r[i];
      if (active[i] && (prio_r[i] == iack_level)) begin
        vec_hit = 1'b1;
        vec_idx = 4'(i);
      end
    end
  end

  always_comb begin
    reg_rd = '0;
    case (word)
      7'd0: reg_rd[0] = ctrl_en;
      7'd1: reg_rd = enable_r;
      7'd2: reg_rd = pending_r;
      7'd3: reg_rd = mode_r;
      7'd4, 7'd5, 7'd6, 7'd7:
        for (int j = 0; j < 4; j++) reg_rd[4*j +: 3] = prio_r[{word[1:0], 2'(j)}];
      default: reg_rd = '0;
    endcase
  end

  always_comb begin
    rd_val = '0;
    if (do_iack) rd_val[7:0] = vec_hit ? (VECTOR_BASE + 8'(vec_idx)) : 8'h18;
    else if (rw) rd_val = reg_rd;
  end

  // Clears only bite on edge-mode bits; a same-cycle rising edge overrides them.
  always_comb begin
    clr_bits = (do_wr && (word == 7'd2)) ? wr_bits : '0;
    if (do_iack && vec_hit) clr_bits[vec_idx] = 1'b1;
  end

  assign set_bits    = irq_in & ~irq_p0 & enable_r;
  assign pending_nxt = IRQ_MASK & ((mode_r & (set_bits | (pending_r & ~clr_bits))) |
                                   (~mode_r & irq_in & enable_r));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      ack       <= 1'b0;
      data_read <= '0;
      ipl_n     <= 3'b111;
      ctrl_en   <= 1'b0;
      enable_r  <= '0;
      pending_r <= '0;
      mode_r    <= '0;
      irq_p0    <= '0;
      for (int i = 0; i < 16; i++) prio_r[i] <= 3'd0;
    end else begin
      irq_p0    <= irq_in;
      pending_r <= pending_nxt;
      ipl_n     <= ~max_lvl;
      case (state)
        ST_IDLE: if (go) begin
          state     <= ST_ACK;
          ack       <= 1'b1;
          data_read <= rd_val;
        end
        ST_ACK: begin
          state     <= ST_HOLD;
          ack       <= 1'b0;
          data_read <= '0;
        end
        ST_HOLD: if (!as) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      if (do_wr) begin
        case (word)
          7'd0: if (lds) ctrl_en <= data_write[0];
          7'd1: enable_r <= merge(enable_r, data_write, lane_mask);
          7'd3: mode_r <= merge(mode_r, data_write, lane_mask);
          7'd4, 7'd5, 7'd6, 7'd7:
            for (int j = 0; j < 4; j++) begin
              if ((j < 2) ? lds : uds)
                prio_r[{word[1:0], 2'(j)}] <= IRQ_MASK[{word[1:0], 2'(j)}] ?
                                              data_write[4*j +: 3] : 3'd0;
            end
          default: ;
        endcase
      end
    end
  end

endmodule
